// File: rtl/bresenham_line_stepper_if.sv
// Handshake bundle for the Bresenham line stepper.
// With LINE_CLIP_EN defined, the clip-window bounds are added.
interface bresenham_line_stepper_if #(
  parameter int WIDTH = 10
) ();
  logic                    start_valid;
  logic                    start_ready;
  logic signed [WIDTH-1:0] x0;
  logic signed [WIDTH-1:0] y0;
  logic signed [WIDTH-1:0] x1;
  logic signed [WIDTH-1:0] y1;
  logic                    abort;
  logic                    pix_valid;
  logic                    pix_ready;
  logic signed [WIDTH-1:0] pix_x;
  logic signed [WIDTH-1:0] pix_y;
  logic                    pix_last;
  logic                    done;
`ifdef LINE_CLIP_EN
  logic        [WIDTH-1:0] clip_xmax;
  logic        [WIDTH-1:0] clip_ymax;
`endif

  modport slave (
    input  start_valid,
    output start_ready,
    input  x0, y0, x1, y1,
    input  abort,
    output pix_valid,
    input  pix_ready,
    output pix_x, pix_y,
    output pix_last,
    output done
`ifdef LINE_CLIP_EN
    , input clip_xmax, clip_ymax
`endif
  );

  modport master (
    output start_valid,
    input  start_ready,
    output x0, y0, x1, y1,
    output abort,
    input  pix_valid,
    output pix_ready,
    input  pix_x, pix_y,
    input  pix_last,
    input  done
`ifdef LINE_CLIP_EN
    , output clip_xmax, clip_ymax
`endif
  );
endinterface

// File: rtl/bresenham_line_stepper.sv
// All-octant Bresenham stepper, one pixel per accepted beat.
// Optional window clipping is built with LINE_CLIP_EN defined.
module bresenham_line_stepper #(
  parameter int WIDTH = 10
) (
  input logic                    clk,
  input logic                    rst,
  bresenham_line_stepper_if.slave io
);
  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STEP
  } state_e;

  state_e state_q;

  logic signed [WIDTH-1:0] x0_q, y0_q;
  logic signed [WIDTH-1:0] x1_q, y1_q;
  logic signed [WIDTH-1:0] maj_q, min_q;
  logic signed [WIDTH-1:0] mend_q;
  logic signed [W1-1:0]    dx_q, dy_q;
  logic signed [W1-1:0]    err_q;
  logic                    steep_q;
  logic                    yneg_q;
  logic                    done_q;

  function automatic logic signed [W1-1:0] sx(
    input logic signed [WIDTH-1:0] v
  );
    return {v[WIDTH-1], v};
  endfunction

  function automatic logic signed [W1-1:0] absv(
    input logic signed [W1-1:0] v
  );
    return v[W1-1] ? -v : v;
  endfunction

  logic signed [W1-1:0]    ax_c, ay_c;
  logic                    steep_c;
  logic                    swap_c;
  logic signed [WIDTH-1:0] ms_c, me_c;
  logic signed [WIDTH-1:0] ns_c, ne_c;
  logic signed [WIDTH-1:0] fms_c, fme_c;
  logic signed [WIDTH-1:0] fns_c, fne_c;
  logic signed [W1-1:0]    dx_c, dy_c;
  logic                    yneg_c;

  always_comb begin
    ax_c    = sx(x1_q) - sx(x0_q);
    ay_c    = sx(y1_q) - sx(y0_q);
    steep_c = absv(ay_c) > absv(ax_c);
    ms_c    = steep_c ? y0_q : x0_q;
    me_c    = steep_c ? y1_q : x1_q;
    ns_c    = steep_c ? x0_q : y0_q;
    ne_c    = steep_c ? x1_q : y1_q;
    // Always walk the major axis upward.
    swap_c  = ms_c > me_c;
    fms_c   = swap_c ? me_c : ms_c;
    fme_c   = swap_c ? ms_c : me_c;
    fns_c   = swap_c ? ne_c : ns_c;
    fne_c   = swap_c ? ns_c : ne_c;
    dx_c    = sx(fme_c) - sx(fms_c);
    dy_c    = absv(sx(fne_c) - sx(fns_c));
    yneg_c  = !(fns_c < fne_c);
  end

  logic signed [W1-1:0]    err_t;
  logic                    inc_min;
  logic signed [WIDTH-1:0] nmaj, nmin;
  logic signed [W1-1:0]    nerr;
  logic signed [WIDTH-1:0] px, py;
  logic                    at_end;

  always_comb begin
    err_t   = err_q - dy_q;
    inc_min = err_t[W1-1];
    nmaj    = maj_q + ONE;
    nmin    = min_q;
    if (inc_min)
      nmin  = yneg_q ? (min_q - ONE) : (min_q + ONE);
    nerr    = inc_min ? (err_t + dx_q) : err_t;
    px      = steep_q ? min_q : maj_q;
    py      = steep_q ? maj_q : min_q;
    at_end  = maj_q == mend_q;
  end

  logic in_win;
  logic end_hit;

`ifdef LINE_CLIP_EN
  logic signed [WIDTH-1:0] nx, ny;
  logic                    nxt_in;

  // In-window pixels of a monotone line are contiguous,
  // so leaving the window means no more pixels follow.
  always_comb begin
    nx      = steep_q ? nmin : nmaj;
    ny      = steep_q ? nmaj : nmin;
    in_win  = !px[WIDTH-1] && !py[WIDTH-1] &&
              ($unsigned(px) <= io.clip_xmax) &&
              ($unsigned(py) <= io.clip_ymax);
    nxt_in  = !nx[WIDTH-1] && !ny[WIDTH-1] &&
              ($unsigned(nx) <= io.clip_xmax) &&
              ($unsigned(ny) <= io.clip_ymax);
    end_hit = at_end || (in_win && !nxt_in);
  end
`else
  always_comb begin
    in_win  = 1'b1;
    end_hit = at_end;
  end
`endif

  logic stepping;
  logic adv;
  logic finish;

  always_comb begin
    stepping = state_q == STEP;
    adv      = stepping && (in_win ? io.pix_ready : 1'b1);
    finish   = adv && end_hit;
  end

  assign io.start_ready = state_q == IDLE;
  assign io.pix_valid   = stepping && in_win;
  assign io.pix_x       = px;
  assign io.pix_y       = py;
  assign io.pix_last    = stepping && in_win && end_hit;
  assign io.done        = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      maj_q   <= '0;
      min_q   <= '0;
      mend_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      steep_q <= 1'b0;
      yneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (io.start_valid) begin
            x0_q    <= io.x0;
            y0_q    <= io.y0;
            x1_q    <= io.x1;
            y1_q    <= io.y1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (io.abort) begin
            state_q <= IDLE;
          end else begin
            steep_q <= steep_c;
            maj_q   <= fms_c;
            min_q   <= fns_c;
            mend_q  <= fme_c;
            dx_q    <= dx_c;
            dy_q    <= dy_c;
            err_q   <= dx_c >>> 1;
            yneg_q  <= yneg_c;
            state_q <= STEP;
          end
        end
        STEP: begin
          if (io.abort) begin
            state_q <= IDLE;
          end else if (finish) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (adv) begin
            maj_q   <= nmaj;
            min_q   <= nmin;
            err_q   <= nerr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bresenham_line_stepper.sv
// Directed bench for bresenham_line_stepper.
// Clip vectors run when LINE_CLIP_EN is defined.
module tb_bresenham_line_stepper;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  bresenham_line_stepper_if #(.WIDTH(W)) io ();

  bresenham_line_stepper #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int n_chk = 0;
  int n_err = 0;
  int ex[$];
  int ey[$];

  task automatic chk(
    input string  tag,
    input integer obs,
    input integer exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic launch(
    input string nm,
    input int a, input int b,
    input int c, input int d,
    input bit lat
  );
    @(negedge clk);
    chk({nm, "_sready"}, io.start_ready, 1);
    io.start_valid = 1'b1;
    io.x0 = W'(a);
    io.y0 = W'(b);
    io.x1 = W'(c);
    io.y1 = W'(d);
    @(negedge clk);
    io.start_valid = 1'b0;
    if (lat) begin
      chk({nm, "_setup_v"}, io.pix_valid, 0);
      chk({nm, "_busy"}, io.start_ready, 0);
    end
  endtask

  task automatic run_line(
    input string nm,
    input int a, input int b,
    input int c, input int d,
    input bit [3:0] pat,
    input bit lat
  );
    int     idx;
    bit     hold;
    bit     rdy;
    integer hx, hy, hl;
    idx  = 0;
    hold = 1'b0;
    hx   = 0;
    hy   = 0;
    hl   = 0;
    launch(nm, a, b, c, d, lat);
    for (int k = 0; k < 3000 && idx < ex.size(); k++) begin
      @(negedge clk);
      rdy = pat[k % 4];
      io.pix_ready = rdy;
      if (lat && k == 0)
        chk({nm, "_lat"}, io.pix_valid, 1);
      if (hold) begin
        chk({nm, "_hold_x"}, io.pix_x, hx);
        chk({nm, "_hold_y"}, io.pix_y, hy);
        chk({nm, "_hold_l"}, io.pix_last, hl);
      end
      if (io.pix_valid && rdy) begin
        chk({nm, "_x"}, io.pix_x, ex[idx]);
        chk({nm, "_y"}, io.pix_y, ey[idx]);
        chk({nm, "_last"}, io.pix_last,
            (idx == ex.size() - 1) ? 1 : 0);
        idx++;
      end
      hold = io.pix_valid && !rdy;
      hx   = io.pix_x;
      hy   = io.pix_y;
      hl   = io.pix_last;
    end
    chk({nm, "_count"}, idx, ex.size());
    @(negedge clk);
    io.pix_ready = 1'b0;
    chk({nm, "_done"}, io.done, 1);
    chk({nm, "_idle_v"}, io.pix_valid, 0);
    chk({nm, "_idle_r"}, io.start_ready, 1);
    @(negedge clk);
    chk({nm, "_done_off"}, io.done, 0);
  endtask

  initial begin
    io.start_valid = 1'b0;
    io.x0 = '0;
    io.y0 = '0;
    io.x1 = '0;
    io.y1 = '0;
    io.abort = 1'b0;
    io.pix_ready = 1'b0;
`ifdef LINE_CLIP_EN
    io.clip_xmax = 10'd511;
    io.clip_ymax = 10'd511;
`endif

    #12;
    chk("rst_sready", io.start_ready, 1);
    chk("rst_valid", io.pix_valid, 0);
    chk("rst_x", io.pix_x, 0);
    chk("rst_y", io.pix_y, 0);
    chk("rst_last", io.pix_last, 0);
    chk("rst_done", io.done, 0);
    @(negedge clk);
    rst = 1'b1;

    ex = '{0, 1, 2, 3, 4, 5};
    ey = '{0, 0, 1, 1, 2, 2};
    run_line("shallow", 0, 0, 5, 2, 4'hF, 1'b1);

    ex = '{1, 1, 2, 2, 2, 2, 3, 3};
    ey = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_line("steep", 3, 7, 1, 0, 4'hF, 1'b1);

`ifndef LINE_CLIP_EN
    ex = '{4};
    ey = '{-3};
    run_line("degen", 4, -3, 4, -3, 4'hF, 1'b1);

    ex = '{0, 1, 2, 3};
    ey = '{0, -1, -2, -3};
    run_line("bp", 0, 0, 3, -3, 4'b1001, 1'b1);

    ex = {};
    ey = {};
    for (int i = -512; i <= 511; i++) begin
      ex.push_back(i);
      ey.push_back(5);
    end
    run_line("full", 511, 5, -512, 5, 4'hF, 1'b0);
`endif

    launch("abort", 0, 0, 9, 0, 1'b1);
    io.pix_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) io.abort = 1'b1;
      chk("abort_x", io.pix_x, k);
    end
    @(negedge clk);
    io.abort = 1'b0;
    chk("abort_valid", io.pix_valid, 0);
    chk("abort_sready", io.start_ready, 1);
    chk("abort_done", io.done, 0);
    @(negedge clk);
    chk("abort_done2", io.done, 0);
    io.pix_ready = 1'b0;

    launch("rstmid", 0, 0, 9, 0, 1'b1);
    io.pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_pre_x", io.pix_x, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_valid", io.pix_valid, 0);
    chk("rstmid_x", io.pix_x, 0);
    chk("rstmid_y", io.pix_y, 0);
    chk("rstmid_last", io.pix_last, 0);
    chk("rstmid_sready", io.start_ready, 1);
    chk("rstmid_done", io.done, 0);
    @(negedge clk);
    io.pix_ready = 1'b0;
    rst = 1'b1;

`ifdef LINE_CLIP_EN
    io.clip_xmax = 10'd3;
    io.clip_ymax = 10'd3;
    ex = '{0, 1, 2, 3};
    ey = '{1, 1, 1, 1};
    run_line("clip", -2, 1, 6, 1, 4'hF, 1'b0);

    begin
      int nv;
      int nd;
      nv = 0;
      nd = 0;
      launch("clipout", -5, -5, -1, -1, 1'b0);
      io.pix_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (io.pix_valid) nv++;
        if (io.done) nd++;
      end
      chk("clipout_valid", nv, 0);
      chk("clipout_done", nd, 1);
      chk("clipout_sready", io.start_ready, 1);
      io.pix_ready = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
